// File: rtl/dbus_arbiter_if.sv
// dbus_arbiter_if: one data-bus link (valid/ready request, valid-only in-order response).
// Latency: none, plain wires grouped for port connection.
// Backpressure: req_ready from the slave side; the response channel cannot be stalled.
interface dbus_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;   // 0 = load
  logic        resp_valid;
  logic [31:0] resp_rdata;

  // Requester side: issues requests, receives responses.
  modport master (
    output req_valid,
    output req_addr,
    output req_wdata,
    output req_wstrb,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata
  );

  // Responder side: accepts requests, returns responses.
  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_wdata,
    input  req_wstrb,
    output req_ready,
    output resp_valid,
    output resp_rdata
  );
endinterface

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master arbiter for the data bus with in-order response routing via an ID tracker.
// Latency: request and response paths are combinational (zero cycles); tracker updates at the clock edge.
// Backpressure: slave ready is passed only to the granted master; a full tracker stalls every request.
module dbus_arbiter #(
  parameter int MAX_OUTST = 4,   // power of two, >= 2
  parameter int CNT_W     = 3    // must be able to hold MAX_OUTST
) (
  input  logic             clk,
  input  logic             rst_n,
  dbus_arbiter_if.slave    m0,   // CPU MEM stage
  dbus_arbiter_if.slave    m1,   // debug / loader master
  dbus_arbiter_if.master   s,    // memory / CSR slave
  output logic [CNT_W-1:0] outst_count,
  output logic             err_unexpected
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  // IDLE: free to pick a winner. LOCKED: a granted request stalled and
  // must be held on the bus until it fires, so it cannot be overtaken.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 lock_id;
  logic                 lock_id_nxt;
  logic                 last_winner;

  logic                 grant;
  logic                 grant_valid;
  logic                 fire;

  // In-order ID tracker: one bit per outstanding request naming its master.
  logic [MAX_OUTST-1:0] id_mem;
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 head_id;
  logic                 resp_hit;

  // Full is judged on the registered count only, so a pop in the same
  // cycle never frees a slot early.
  assign full        = (count == CNT_W'(MAX_OUTST));
  assign empty       = (count == '0);
  assign head_id     = id_mem[head];
  assign resp_hit    = s.resp_valid & ~empty;
  assign push        = fire;
  assign pop         = resp_hit;
  assign outst_count = count;

  // Grant selection, request forwarding and FSM next-state.
  always_comb begin
    grant        = 1'b0;
    grant_valid  = 1'b0;
    state_nxt    = state;
    lock_id_nxt  = lock_id;
    s.req_valid  = 1'b0;
    s.req_addr   = '0;
    s.req_wdata  = '0;
    s.req_wstrb  = '0;
    m0.req_ready = 1'b0;
    m1.req_ready = 1'b0;
    fire         = 1'b0;

    case (state)
      IDLE: begin
        if (m0.req_valid && m1.req_valid) begin
          // Tie: the master that did not win last time goes first.
          grant       = ~last_winner;
          grant_valid = 1'b1;
        end else if (m0.req_valid) begin
          grant       = 1'b0;
          grant_valid = 1'b1;
        end else if (m1.req_valid) begin
          grant       = 1'b1;
          grant_valid = 1'b1;
        end
      end
      LOCKED: begin
        // The other master is ignored until the locked request fires.
        grant       = lock_id;
        grant_valid = lock_id ? m1.req_valid : m0.req_valid;
      end
      default: begin
        grant       = 1'b0;
        grant_valid = 1'b0;
      end
    endcase

    if (grant_valid) begin
      s.req_valid = ~full;
      if (grant) begin
        s.req_addr   = m1.req_addr;
        s.req_wdata  = m1.req_wdata;
        s.req_wstrb  = m1.req_wstrb;
        m1.req_ready = s.req_ready & ~full;
      end else begin
        s.req_addr   = m0.req_addr;
        s.req_wdata  = m0.req_wdata;
        s.req_wstrb  = m0.req_wstrb;
        m0.req_ready = s.req_ready & ~full;
      end
    end

    fire = s.req_valid & s.req_ready;

    case (state)
      IDLE: begin
        if (grant_valid && !fire) begin
          state_nxt   = LOCKED;
          lock_id_nxt = grant;
        end
      end
      LOCKED: begin
        // Leaving on a dropped valid only matters for a master that breaks
        // the hold-until-ready rule; it keeps the bus from wedging.
        if (fire || !grant_valid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, lock owner and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lock_id     <= 1'b0;
      last_winner <= 1'b1;   // m0 wins the first tie after reset
    end else begin
      state   <= state_nxt;
      lock_id <= lock_id_nxt;
      if (fire) begin
        last_winner <= grant;
      end
    end
  end

  // ID tracker: push the winner on fire, pop the head on each response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_mem <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        id_mem[tail] <= grant;
        tail         <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Response routing: the tracker head names the master that owns this response.
  always_comb begin
    m0.resp_valid = 1'b0;
    m0.resp_rdata = '0;
    m1.resp_valid = 1'b0;
    m1.resp_rdata = '0;
    if (resp_hit) begin
      if (head_id) begin
        m1.resp_valid = 1'b1;
        m1.resp_rdata = s.resp_rdata;
      end else begin
        m0.resp_valid = 1'b1;
        m0.resp_rdata = s.resp_rdata;
      end
    end
  end

  // Sticky flag for a response that arrives with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_unexpected <= 1'b0;
    end else if (s.resp_valid && empty) begin
      err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: scenario tasks for the two-master data-bus arbiter.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Expected response routing is queued when a request is accepted and popped when its response is driven.
module tb_dbus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [2:0] outst_count;
  logic       err_unexpected;

  dbus_arbiter_if m0_if ();
  dbus_arbiter_if m1_if ();
  dbus_arbiter_if s_if ();

  dbus_arbiter #(
    .MAX_OUTST (4),
    .CNT_W     (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .s              (s_if),
    .outst_count    (outst_count),
    .err_unexpected (err_unexpected)
  );

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [65:0] resp_got;
  logic [65:0] resp_exp;
  logic [31:0] exp_addr;
  logic        g;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, got timeout, required summary");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_inputs();
    m0_if.req_valid  = 1'b0;
    m0_if.req_addr   = '0;
    m0_if.req_wdata  = '0;
    m0_if.req_wstrb  = '0;
    m1_if.req_valid  = 1'b0;
    m1_if.req_addr   = '0;
    m1_if.req_wdata  = '0;
    m1_if.req_wstrb  = '0;
    s_if.req_ready   = 1'b0;
    s_if.resp_valid  = 1'b0;
    s_if.resp_rdata  = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    clear_inputs();
    s_if.req_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({s_if.req_valid, m0_if.req_ready, m1_if.req_ready, m0_if.resp_valid, m1_if.resp_valid} !== 5'b0)
      $display("FAIL rst_valids: got %b required 00000",
               {s_if.req_valid, m0_if.req_ready, m1_if.req_ready, m0_if.resp_valid, m1_if.resp_valid});
    else n_pass++;
    n_checks++;
    if ({s_if.req_addr, s_if.req_wdata, s_if.req_wstrb} !== 68'h0)
      $display("FAIL rst_payload: got %h required 0", {s_if.req_addr, s_if.req_wdata, s_if.req_wstrb});
    else n_pass++;
    n_checks++;
    if (outst_count !== 3'd0) $display("FAIL rst_count: got %0d required 0", outst_count);
    else n_pass++;
    n_checks++;
    if (err_unexpected !== 1'b0) $display("FAIL rst_err: got %b required 0", err_unexpected);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    s_if.req_ready = 1'b0;
    sb.delete();
  endtask

  task automatic test_single();
    m0_if.req_valid = 1'b1;
    m0_if.req_addr  = 32'h100;
    m0_if.req_wstrb = 4'h0;
    s_if.req_ready  = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({s_if.req_valid, s_if.req_addr, s_if.req_wstrb} !== {1'b1, 32'h100, 4'h0})
      $display("FAIL single_req: got %h required %h", {s_if.req_valid, s_if.req_addr, s_if.req_wstrb},
               {1'b1, 32'h100, 4'h0});
    else n_pass++;
    n_checks++;
    if ({m0_if.req_ready, m1_if.req_ready} !== 2'b10)
      $display("FAIL single_ready: got %b required 10", {m0_if.req_ready, m1_if.req_ready});
    else n_pass++;
    e.id = 1'b0; e.data = 32'hDEADBEEF; sb.push_back(e);
    @(posedge clk);
    #1 m0_if.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outst_count !== 3'd1) $display("FAIL single_count1: got %0d required 1", outst_count);
    else n_pass++;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      s_if.resp_valid = 1'b1;
      s_if.resp_rdata = e.data;
      @(negedge clk);
      resp_got = {m0_if.resp_valid, m0_if.resp_rdata, m1_if.resp_valid, m1_if.resp_rdata};
      resp_exp = e.id ? {1'b0, 32'h0, 1'b1, e.data} : {1'b1, e.data, 1'b0, 32'h0};
      n_checks++;
      if (resp_got !== resp_exp) $display("FAIL single_resp: got %h required %h", resp_got, resp_exp);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    s_if.resp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outst_count !== 3'd0) $display("FAIL single_count0: got %0d required 0", outst_count);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alternate();
    apply_reset();
    m0_if.req_valid = 1'b1; m0_if.req_addr = 32'h200;
    m1_if.req_valid = 1'b1; m1_if.req_addr = 32'h300;
    s_if.req_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g = i[0];
      exp_addr = g ? 32'h300 : 32'h200;
      n_checks++;
      if (s_if.req_addr !== exp_addr)
        $display("FAIL alt_addr%0d: got %h required %h", i, s_if.req_addr, exp_addr);
      else n_pass++;
      n_checks++;
      if ({m0_if.req_ready, m1_if.req_ready} !== {~g, g})
        $display("FAIL alt_ready%0d: got %b required %b", i, {m0_if.req_ready, m1_if.req_ready}, {~g, g});
      else n_pass++;
      e.id = g; e.data = 32'hA5A50000 + 32'(i); sb.push_back(e);
      @(posedge clk);
      #1;
    end
    m0_if.req_valid = 1'b0;
    m1_if.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outst_count !== 3'd4) $display("FAIL alt_count4: got %0d required 4", outst_count);
    else n_pass++;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      s_if.resp_valid = 1'b1;
      s_if.resp_rdata = e.data;
      @(negedge clk);
      resp_got = {m0_if.resp_valid, m0_if.resp_rdata, m1_if.resp_valid, m1_if.resp_rdata};
      resp_exp = e.id ? {1'b0, 32'h0, 1'b1, e.data} : {1'b1, e.data, 1'b0, 32'h0};
      n_checks++;
      if (resp_got !== resp_exp) $display("FAIL alt_resp: got %h required %h", resp_got, resp_exp);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    s_if.resp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outst_count !== 3'd0) $display("FAIL alt_count0: got %0d required 0", outst_count);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    apply_reset();
    m1_if.req_valid = 1'b1;
    m1_if.req_addr  = 32'h400;
    m1_if.req_wdata = 32'hCAFEF00D;
    m1_if.req_wstrb = 4'hF;
    s_if.req_ready  = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({s_if.req_valid, s_if.req_addr, s_if.req_wdata, s_if.req_wstrb, m1_if.req_ready} !==
        {1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 1'b0})
      $display("FAIL stall_fwd: got %h required %h",
               {s_if.req_valid, s_if.req_addr, s_if.req_wdata, s_if.req_wstrb, m1_if.req_ready},
               {1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 1'b0});
    else n_pass++;
    @(posedge clk);
    #1;
    m0_if.req_valid = 1'b1;
    m0_if.req_addr  = 32'h500;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({s_if.req_addr, m0_if.req_ready} !== {32'h400, 1'b0})
        $display("FAIL stall_hold%0d: got %h required %h", i, {s_if.req_addr, m0_if.req_ready}, {32'h400, 1'b0});
      else n_pass++;
      @(posedge clk);
      #1;
    end
    s_if.req_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({s_if.req_addr, m0_if.req_ready, m1_if.req_ready} !== {32'h400, 2'b01})
      $display("FAIL stall_fire: got %h required %h", {s_if.req_addr, m0_if.req_ready, m1_if.req_ready},
               {32'h400, 2'b01});
    else n_pass++;
    e.id = 1'b1; e.data = 32'h11110001; sb.push_back(e);
    @(posedge clk);
    #1 m1_if.req_addr = 32'h404;
    m1_if.req_wstrb = 4'h0;
    @(negedge clk);
    n_checks++;
    if ({s_if.req_addr, m0_if.req_ready, m1_if.req_ready} !== {32'h500, 2'b10})
      $display("FAIL stall_next: got %h required %h", {s_if.req_addr, m0_if.req_ready, m1_if.req_ready},
               {32'h500, 2'b10});
    else n_pass++;
    e.id = 1'b0; e.data = 32'h22220002; sb.push_back(e);
    @(posedge clk);
    #1;
    m0_if.req_valid = 1'b0;
    m1_if.req_valid = 1'b0;
    s_if.req_ready  = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      s_if.resp_valid = 1'b1;
      s_if.resp_rdata = e.data;
      @(negedge clk);
      resp_got = {m0_if.resp_valid, m0_if.resp_rdata, m1_if.resp_valid, m1_if.resp_rdata};
      resp_exp = e.id ? {1'b0, 32'h0, 1'b1, e.data} : {1'b1, e.data, 1'b0, 32'h0};
      n_checks++;
      if (resp_got !== resp_exp) $display("FAIL stall_resp: got %h required %h", resp_got, resp_exp);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    s_if.resp_valid = 1'b0;
  endtask

  task automatic test_full();
    apply_reset();
    m0_if.req_valid = 1'b1;
    m0_if.req_wstrb = 4'h0;
    s_if.req_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m0_if.req_addr = 32'h600 + 32'(4 * i);
      @(negedge clk);
      n_checks++;
      if ({s_if.req_valid, m0_if.req_ready} !== 2'b11)
        $display("FAIL full_fill%0d: got %b required 11", i, {s_if.req_valid, m0_if.req_ready});
      else n_pass++;
      e.id = 1'b0; e.data = 32'h60000000 + 32'(i); sb.push_back(e);
      @(posedge clk);
      #1;
    end
    m0_if.req_addr = 32'h610;
    @(negedge clk);
    n_checks++;
    if ({outst_count, s_if.req_valid, m0_if.req_ready} !== {3'd4, 2'b00})
      $display("FAIL full_block: got %b required %b", {outst_count, s_if.req_valid, m0_if.req_ready},
               {3'd4, 2'b00});
    else n_pass++;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    s_if.resp_valid = 1'b1;
    s_if.resp_rdata = e.data;
    @(negedge clk);
    n_checks++;
    if ({s_if.req_valid, m0_if.req_ready} !== 2'b00)
      $display("FAIL full_popblock: got %b required 00", {s_if.req_valid, m0_if.req_ready});
    else n_pass++;
    resp_got = {m0_if.resp_valid, m0_if.resp_rdata, m1_if.resp_valid, m1_if.resp_rdata};
    resp_exp = e.id ? {1'b0, 32'h0, 1'b1, e.data} : {1'b1, e.data, 1'b0, 32'h0};
    n_checks++;
    if (resp_got !== resp_exp) $display("FAIL full_resp: got %h required %h", resp_got, resp_exp);
    else n_pass++;
    @(posedge clk);
    #1 s_if.resp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({outst_count, s_if.req_valid, m0_if.req_ready, s_if.req_addr} !== {3'd3, 2'b11, 32'h610})
      $display("FAIL full_accept5: got %h required %h", {outst_count, s_if.req_valid, m0_if.req_ready, s_if.req_addr},
               {3'd3, 2'b11, 32'h610});
    else n_pass++;
    e.id = 1'b0; e.data = 32'h60000004; sb.push_back(e);
    @(posedge clk);
    #1 m0_if.req_valid = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      s_if.resp_valid = 1'b1;
      s_if.resp_rdata = e.data;
      @(negedge clk);
      resp_got = {m0_if.resp_valid, m0_if.resp_rdata, m1_if.resp_valid, m1_if.resp_rdata};
      resp_exp = e.id ? {1'b0, 32'h0, 1'b1, e.data} : {1'b1, e.data, 1'b0, 32'h0};
      n_checks++;
      if (resp_got !== resp_exp) $display("FAIL full_drain: got %h required %h", resp_got, resp_exp);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    s_if.resp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (outst_count !== 3'd0) $display("FAIL full_count0: got %0d required 0", outst_count);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unexpected();
    apply_reset();
    s_if.resp_valid = 1'b1;
    s_if.resp_rdata = 32'h12345678;
    @(negedge clk);
    n_checks++;
    if ({m0_if.resp_valid, m1_if.resp_valid, err_unexpected} !== 3'b000)
      $display("FAIL unexp_drop: got %b required 000", {m0_if.resp_valid, m1_if.resp_valid, err_unexpected});
    else n_pass++;
    @(posedge clk);
    #1 s_if.resp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_unexpected !== 1'b1) $display("FAIL unexp_set: got %b required 1", err_unexpected);
    else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (err_unexpected !== 1'b1) $display("FAIL unexp_sticky: got %b required 1", err_unexpected);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (err_unexpected !== 1'b0) $display("FAIL unexp_clear: got %b required 0", err_unexpected);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    m0_if.req_valid = 1'b1;
    m0_if.req_addr  = 32'h700;
    s_if.req_ready  = 1'b1;
    @(posedge clk);
    #1 m0_if.req_valid = 1'b0;
    m1_if.req_valid = 1'b1;
    m1_if.req_addr  = 32'h780;
    @(posedge clk);
    #1 m1_if.req_addr = 32'h784;
    s_if.req_ready = 1'b0;
    @(posedge clk);
    #1 m0_if.req_valid = 1'b1;
    m0_if.req_addr = 32'h708;
    @(negedge clk);
    n_checks++;
    if ({outst_count, s_if.req_addr} !== {3'd2, 32'h784})
      $display("FAIL mid_locked: got %h required %h", {outst_count, s_if.req_addr}, {3'd2, 32'h784});
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({outst_count, err_unexpected} !== 4'b0000)
      $display("FAIL mid_clear: got %b required 0000", {outst_count, err_unexpected});
    else n_pass++;
    n_checks++;
    if (s_if.req_addr !== 32'h708)
      $display("FAIL mid_idle: got %h required %h", s_if.req_addr, 32'h708);
    else n_pass++;
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    m0_if.req_valid = 1'b0;
    m1_if.req_valid = 1'b0;
    s_if.resp_valid = 1'b1;
    s_if.resp_rdata = 32'h0BADF00D;
    @(negedge clk);
    n_checks++;
    if ({m0_if.resp_valid, m1_if.resp_valid} !== 2'b00)
      $display("FAIL mid_late: got %b required 00", {m0_if.resp_valid, m1_if.resp_valid});
    else n_pass++;
    @(posedge clk);
    #1 s_if.resp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err_unexpected !== 1'b1) $display("FAIL mid_err: got %b required 1", err_unexpected);
    else n_pass++;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_alternate();
    test_stall();
    test_full();
    test_unexpected();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-requester arbiter for the single data bus (dbus) between the pipeline MEM stage and the memory/CSR slave.
- Port m0 is the CPU MEM stage; port m1 is the debug/loader master.
- Request channel: valid/ready. Response channel: valid-only, strictly in order.
- An ID FIFO records which master issued each accepted request, so each response is routed back to that master.

Parameters:
- MAX_OUTST, 4, outstanding-request tracker depth; power of two, >= 2.
- CNT_W, 3, width of outst_count; must hold MAX_OUTST.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req_valid  in  1  master 0 request valid.
- m0_req_ready  out  1  master 0 request accepted.
- m0_req_addr  in  32  master 0 byte address.
- m0_req_wdata  in  32  master 0 store data.
- m0_req_wstrb  in  4  master 0 byte strobes; 0 = load.
- m0_resp_valid  out  1  master 0 response.
- m0_resp_rdata  out  32  master 0 load data.
- m1_req_valid, m1_req_ready, m1_req_addr, m1_req_wdata, m1_req_wstrb, m1_resp_valid, m1_resp_rdata  same as m0, for master 1.
- s_req_valid  out  1  slave request valid.
- s_req_ready  in  1  slave accepts request.
- s_req_addr  out  32  forwarded address.
- s_req_wdata  out  32  forwarded store data.
- s_req_wstrb  out  4  forwarded strobes.
- s_resp_valid  in  1  slave response, in order.
- s_resp_rdata  in  32  slave read data.
- outst_count  out  CNT_W  accepted requests not yet answered.
- err_unexpected  out  1  sticky: a response arrived with no outstanding request.

Behaviour:
- Reset (async, rst_n low): state=IDLE, last_winner=1 (so m0 wins the first tie), tracker empty, outst_count=0, err_unexpected=0.
- All request-side outputs are combinational from current state and inputs. Every output is therefore 0 while reset is asserted and all m*_req_valid are 0.
- full = (outst_count == MAX_OUTST). Full blocks new requests even if a pop occurs in the same cycle.
- State IDLE, grant selection (combinational):
  - Only one master valid: that master.
  - Both valid: the master that is not last_winner.
  - Neither valid: no grant.
- State LOCKED: grant = lock_id, regardless of the other master.
- Request forwarding:
  - s_req_valid = grant_valid & !full.
  - s_req_addr/wdata/wstrb = granted master's fields; zero when no grant.
  - Granted master's req_ready = s_req_ready & !full. The other master's req_ready = 0.
  - fire = s_req_valid & s_req_ready.
- Transitions:
  - IDLE -> LOCKED when grant_valid & !fire; lock_id <= grant.
  - LOCKED -> IDLE on fire.
  - Masters must hold valid and payload stable until ready, so a stalled request can never be overtaken.
- On fire: push grant ID into the tracker; last_winner <= grant.
- Response routing (combinational, zero latency):
  - When s_resp_valid & tracker non-empty: m{head}_resp_valid = 1 and m{head}_resp_rdata = s_resp_rdata. Tracker pops at the clock edge.
  - Non-selected master's resp_valid = 0 and resp_rdata = 0.
- Empty tracker with s_resp_valid: response dropped, both resp_valid stay 0, err_unexpected <= 1 until reset.
- Simultaneous push and pop: outst_count unchanged; head and tail both advance.
- Head and tail pointers wrap modulo MAX_OUTST.
- A response to a request fired in cycle N may arrive no earlier than cycle N+1; same-cycle responses are not supported.
- Reset mid-transaction: tracker cleared, in-flight responses forgotten. Late responses after reset set err_unexpected.

Test Plan:
- m0 load to 0x100 alone, s_req_ready=1, response 0xDEADBEEF two cycles later -> s_req_addr=0x100 in cycle 0; m0_resp_valid=1 with rdata 0xDEADBEEF; m1_resp_valid=0; outst_count goes 1 then 0.
- m0 and m1 held valid for 4 cycles, s_req_ready=1 -> grants alternate m0,m1,m0,m1; tracker order {0,1,0,1}; four responses route to m0,m1,m0,m1.
- m1 granted with s_req_ready=0 for 3 cycles while m0 raises valid -> s_req_addr stays on m1's address; m0_req_ready=0 until m1 fires; m0 wins the next cycle.
- MAX_OUTST=4, issue 4 loads with no response -> outst_count=4 and s_req_valid=0 on the 5th. One response (pop) in that cycle still blocks; the 5th request is accepted next cycle.
- s_resp_valid pulse with empty tracker -> no m*_resp_valid; err_unexpected=1 and stays 1 until rst_n low.
- Assert rst_n low asynchronously with 2 outstanding -> outst_count=0 immediately; state IDLE; err_unexpected=0.
